// File: rtl/p3p_pkg.sv
// Shared types for the transmit framer: sample word and handshake FSM states.
package p3p_pkg;

  typedef logic signed [15:0] num;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE
  } tx_state_t;

endpackage

// File: rtl/uart_tx_handshake.sv
// Drives the uart send_data/tx_ready handshake for one frame at a time and counts completions.
module uart_tx_handshake
  import p3p_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             tx_ready,
  output logic             send_data,
  output logic             idle,
  output logic [CNT_W-1:0] frames_sent
);

  tx_state_t state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      send_data   <= 1'b0;
      frames_sent <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= SEND;
            send_data <= 1'b1;
          end
        end
        SEND: begin
          // The uart acknowledges by dropping tx_ready once it has latched the frame.
          if (!tx_ready) begin
            state_q   <= WAIT_DONE;
            send_data <= 1'b0;
          end
        end
        WAIT_DONE: begin
          if (tx_ready) begin
            state_q     <= IDLE;
            frames_sent <= frames_sent + CNT_W'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          send_data <= 1'b0;
        end
      endcase
    end
  end

  assign idle = (state_q == IDLE);

endmodule

// File: rtl/vector_tx_framer.sv
// Packs incoming samples into fixed-size frames, double-buffers them and hands them to the uart.
module vector_tx_framer
  import p3p_pkg::*;
#(
  parameter int unsigned n_tx_nums = 5,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  num                   in_num,
  input  logic                 flush,
  input  logic                 tx_ready,
  output logic                 send_data,
  output num [n_tx_nums-1:0]   tx_nums,
  output logic                 busy,
  output logic                 overflow,
  output logic [CNT_W-1:0]     frames_sent
);

  localparam int unsigned     CntW    = $clog2(n_tx_nums + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(n_tx_nums - 1);

  num [n_tx_nums-1:0] fill_q;
  logic [CntW-1:0]    count_q;
  logic [CntW-1:0]    count_next;
  logic               pending_q;
  logic               idle;
  logic               transfer;
  logic               occupied;
  logic               accept;
  logic               drop;
  logic               last_word;
  logic               close_flush;
  logic               frame_done;

  always_comb begin
    transfer    = idle & pending_q & tx_ready;
    // A transfer empties the fill buffer in the same cycle, so that cycle's sample is kept.
    occupied    = pending_q & ~transfer;
    accept      = in_valid & ~occupied;
    drop        = in_valid & occupied;
    count_next  = count_q + CntW'(accept);
    last_word   = accept & (count_q == LastIdx);
    close_flush = flush & ~occupied & (count_next != '0);
    frame_done  = last_word | close_flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q    <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      tx_nums   <= '0;
      overflow  <= 1'b0;
    end else begin
      if (transfer) begin
        tx_nums <= fill_q;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      for (int i = 0; i < int'(n_tx_nums); i++) begin
        if (accept && (count_q == CntW'(i))) begin
          fill_q[i] <= in_num;
        end else if (close_flush && (CntW'(i) >= count_next)) begin
          fill_q[i] <= '0;
        end
      end
      if (frame_done) begin
        pending_q <= 1'b1;
        count_q   <= '0;
      end else begin
        if (transfer) begin
          pending_q <= 1'b0;
        end
        count_q <= count_next;
      end
    end
  end

  uart_tx_handshake #(
    .CNT_W(CNT_W)
  ) u_handshake (
    .clk        (clk),
    .reset      (reset),
    .start      (transfer),
    .tx_ready   (tx_ready),
    .send_data  (send_data),
    .idle       (idle),
    .frames_sent(frames_sent)
  );

  assign busy = ~idle | pending_q;

endmodule

// File: tb/tb_vector_tx_framer.sv
// Directed bench for vector_tx_framer: framing, flush padding, overflow, handshake and reset.
module tb_vector_tx_framer;
  import p3p_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  num          in_num;
  logic        flush;
  logic        tx_ready;
  logic        send_data;
  num [4:0]    tx_nums;
  logic        busy;
  logic        overflow;
  logic [15:0] frames_sent;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_frames;

  vector_tx_framer #(
    .n_tx_nums(5),
    .CNT_W    (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_num     (in_num),
    .flush      (flush),
    .tx_ready   (tx_ready),
    .send_data  (send_data),
    .tx_nums    (tx_nums),
    .busy       (busy),
    .overflow   (overflow),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    in_valid = 1'b1;
    in_num   = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    tx_ready = 1'b0;
    tick();
    chk({tag, "_sd_wait"}, 80'(send_data), 80'd0);
    tx_ready = 1'b1;
    tick();
    exp_frames = exp_frames + 16'd1;
    chk({tag, "_frames"}, 80'(frames_sent), 80'(exp_frames));
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_num   = '0;
    flush    = 1'b0;
    tx_ready = 1'b1;
    exp_frames = 16'd0;
    tick();
    tick();
    chk("rst_send_data", 80'(send_data), 80'd0);
    chk("rst_busy", 80'(busy), 80'd0);
    chk("rst_overflow", 80'(overflow), 80'd0);
    chk("rst_frames", 80'(frames_sent), 80'd0);
    chk("rst_tx_nums", tx_nums, 80'd0);
    reset = 1'b0;

    // Full frame, latency of send_data and word ordering.
    push(16'hF6A5);
    push(16'hFEDA);
    push(16'hFD3C);
    push(16'h00C1);
    push(16'hDABE);
    chk("f1_sd_early", 80'(send_data), 80'd0);
    chk("f1_busy_pending", 80'(busy), 80'd1);
    tick();
    chk("f1_sd", 80'(send_data), 80'd1);
    chk("f1_tx_nums", tx_nums, {16'hDABE, 16'h00C1, 16'hFD3C, 16'hFEDA, 16'hF6A5});
    finish_frame("f1");
    chk("f1_busy_done", 80'(busy), 80'd0);

    // Partial frame closed by flush is zero padded.
    push(16'h0001);
    push(16'h0002);
    push(16'h0003);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("fl_sd", 80'(send_data), 80'd1);
    chk("fl_tx_nums", tx_nums, {16'h0000, 16'h0000, 16'h0003, 16'h0002, 16'h0001});
    finish_frame("fl");

    // Flush on an empty buffer does nothing.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("fl0_sd", 80'(send_data), 80'd0);
    chk("fl0_busy", 80'(busy), 80'd0);

    // Sample and flush together, then tx_ready held high for three cycles.
    push(16'h1111);
    in_valid = 1'b1;
    in_num   = 16'h2222;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    tick();
    chk("fv_sd", 80'(send_data), 80'd1);
    chk("fv_tx_nums", tx_nums, {16'h0000, 16'h0000, 16'h0000, 16'h2222, 16'h1111});
    tick();
    chk("hold_sd_2", 80'(send_data), 80'd1);
    tick();
    chk("hold_sd_3", 80'(send_data), 80'd1);
    chk("hold_frames", 80'(frames_sent), 80'(exp_frames));
    finish_frame("hold");
    tick();
    chk("hold_frames_once", 80'(frames_sent), 80'(exp_frames));
    chk("hold_sd_idle", 80'(send_data), 80'd0);

    // Twelve samples at full rate while the uart stays busy: 11 and 12 are dropped.
    for (int i = 1; i <= 12; i++) begin
      if (i == 7) tx_ready = 1'b0;
      push(16'h1000 + 16'(i));
    end
    chk("ov_overflow", 80'(overflow), 80'd1);
    chk("ov_sd_wait", 80'(send_data), 80'd0);
    chk("ov_busy", 80'(busy), 80'd1);
    chk("ov_tx_nums1", tx_nums, {16'h1005, 16'h1004, 16'h1003, 16'h1002, 16'h1001});
    tx_ready = 1'b1;
    tick();
    exp_frames = exp_frames + 16'd1;
    chk("ov_frames1", 80'(frames_sent), 80'(exp_frames));
    chk("ov_sd_gap", 80'(send_data), 80'd0);
    tick();
    chk("ov_sd2", 80'(send_data), 80'd1);
    chk("ov_tx_nums2", tx_nums, {16'h100A, 16'h1009, 16'h1008, 16'h1007, 16'h1006});
    finish_frame("ov2");
    chk("ov_busy_done", 80'(busy), 80'd0);
    chk("ov_sticky", 80'(overflow), 80'd1);

    // Reset while waiting for the uart abandons the frame.
    for (int i = 0; i < 5; i++) push(16'hA000 + 16'(i));
    tick();
    chk("rw_sd", 80'(send_data), 80'd1);
    tx_ready = 1'b0;
    tick();
    chk("rw_busy_wait", 80'(busy), 80'd1);
    reset    = 1'b1;
    tx_ready = 1'b1;
    tick();
    reset = 1'b0;
    exp_frames = 16'd0;
    chk("rw_send_data", 80'(send_data), 80'd0);
    chk("rw_tx_nums", tx_nums, 80'd0);
    chk("rw_frames", 80'(frames_sent), 80'd0);
    chk("rw_busy", 80'(busy), 80'd0);
    chk("rw_overflow", 80'(overflow), 80'd0);
    for (int i = 1; i <= 5; i++) push(16'h0B00 + 16'(i));
    tick();
    chk("post_sd", 80'(send_data), 80'd1);
    chk("post_tx_nums", tx_nums, {16'h0B05, 16'h0B04, 16'h0B03, 16'h0B02, 16'h0B01});
    finish_frame("post");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vector_tx_framer.md
Name: vector_tx_framer

Overview:
Sits directly upstream of the uart transmit side. Collects a stream of signed 16-bit num samples from the processing pipeline into frames of n_tx_nums words, double-buffers them, and drives the uart tx_nums/send_data/tx_ready handshake. Collection of frame k+1 continues while frame k is on the wire. A sticky flag reports dropped samples.

Parameters:
n_tx_nums, 5, words per frame; must equal the uart n_tx_nums (range 1..16)
CNT_W, 16, width of frames_sent counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  in_num is valid this cycle
in_num  in  num (16, signed)  sample from pipeline
flush  in  1  close partial frame: zero-pad and queue it
tx_ready  in  1  from uart; high = transmitter idle
send_data  out  1  to uart; request transmission of tx_nums
tx_nums  out  num [n_tx_nums-1:0]  frame to uart; element 0 transmitted first
busy  out  1  high when state != IDLE or a frame is pending
overflow  out  1  sticky; a sample was dropped
frames_sent  out  CNT_W  frames completed by uart, wraps

Behaviour:
- Reset (sync, high): fill count=0, pending=0, state=IDLE, send_data=0, tx_nums all 0, overflow=0, frames_sent=0, busy=0. Reset mid-transmission abandons the frame; no handshake completion is awaited.
- Fill buffer: sample accepted on in_valid goes to fill[count], count++. When count reaches n_tx_nums-1 and a sample is accepted, the frame is complete: pending<=1, count<=0.
- Sample arriving while pending=1 and not transferred this same cycle: dropped, overflow<=1. Only cleared by reset.
- flush with count>0: words count..n_tx_nums-1 zeroed, pending<=1, count<=0. flush with count=0: ignored. flush and in_valid in the same cycle: sample stored first at fill[count], then padding applies. That can complete the frame normally. flush while pending=1: ignored. A sample in that cycle follows the drop rule.
- Transfer: in IDLE with pending=1 and tx_ready=1: tx_nums<=fill, pending<=0, state<=SEND. New samples in the same cycle are accepted into an emptied fill buffer (no drop).
- FSM:
  - IDLE: send_data=0. Transition as above.
  - SEND: send_data=1. Stay while tx_ready=1. On tx_ready=0 go to WAIT_DONE.
  - WAIT_DONE: send_data=0. On tx_ready=1: frames_sent++ (wraps), state<=IDLE.
- tx_nums is held stable from entry to SEND until return to IDLE.
- Latency: last sample accepted at edge t gives pending at t. Given tx_ready=1, send_data is registered high at edge t+1. The first cycle of send_data is the second cycle after the last in_valid cycle.
- Back-to-back: the pending frame transfers in the first IDLE cycle with tx_ready=1.
- busy = (state!=IDLE) | pending.
- No arithmetic on samples; values pass bit-exact.

Decomposition:
- Shared package p3p_pkg: typedef num (logic signed [15:0]) and the FSM state enum tx_state_t {IDLE, SEND, WAIT_DONE}.
- One natural sub-module: uart_tx_handshake. It holds the FSM, send_data and the frames_sent counter, with inputs start and tx_ready and output idle.
- Fill/pending logic stays in the top module.

Test Plan:
- Reset, then 5 samples 16'hF6A5, 16'hFEDA, 16'hFD3C, 16'h00C1, 16'hDABE on consecutive cycles; uart model tx_ready high. Expect send_data high two cycles after the last sample, tx_nums[0..4] equal to those values, frames_sent=1 after tx_ready returns high.
- Loopback with the real uart (rx=tx), n=5. Expect uart rx_nums to equal the frame sent and rx_available to pulse once, within about 140us.
- 12 samples at full rate while uart is busy ~60us per frame. Expect frame 1 sent, frame 2 pending, samples 11..12 dropped, overflow=1, frames_sent=2 eventually, tx_nums of frame 2 equal to samples 6..10.
- 3 samples 16'h0001, 16'h0002, 16'h0003 then flush. Expect tx_nums = {1,2,3,0,0}. flush with count=0 produces no send_data.
- Uart holds tx_ready high for 3 cycles after send_data. Expect send_data held high those 3 cycles, dropping the cycle after tx_ready=0, and exactly one frame counted.
- Assert reset while in WAIT_DONE. Expect next cycle send_data=0, tx_nums=0, frames_sent=0, busy=0. The subsequent new frame is sent normally.
